coherence_mem_arbiter: RTL and testbench

// Bus controller directly downstream of both CPUs' dcache and icache (cache-control side). Serialises
// all cache requests onto the single RAM port. Holds a dcache grant across a multi-word block transfer
// (cctrans). Broadcasts snoop-wait and invalidate to the other dcache so blocks stay coherent.

---
 rtl/coherence_mem_arbiter_if.sv | 46 ++++
 rtl/coherence_mem_arbiter.sv | 119 +++++++++++
 tb/tb_coherence_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_mem_arbiter_if.sv
// Cache/RAM bus bundle between both cores' caches and the memory arbiter.
// Latency: wires only. Backpressure: per-requester wait lines driven by the arbiter.
// Ports: icache (iREN/iaddr/iwait/iload), dcache (dREN/dWEN/daddr/dstore/dwait/dload),
//        coherence (cctrans/ccwrite/ccwait/ccinv/ccsnoopaddr), RAM (ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate).
//        slave = arbiter view, master = cache/RAM side view.
interface coherence_mem_arbiter_if #(
  parameter int CPUS = 2
);
  // icache side
  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0][31:0]  iaddr;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0][31:0]  iload;
  // dcache side
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS-1:0][31:0]  daddr;
  logic [CPUS-1:0][31:0]  dstore;
  logic [CPUS-1:0]        dwait;
  logic [CPUS-1:0][31:0]  dload;
  // coherence
  logic [CPUS-1:0]        cctrans;
  logic [CPUS-1:0]        ccwrite;
  logic [CPUS-1:0]        ccwait;
  logic [CPUS-1:0]        ccinv;
  logic [CPUS-1:0][31:0]  ccsnoopaddr;
  // RAM port
  logic                   ramREN;
  logic                   ramWEN;
  logic [31:0]            ramaddr;
  logic [31:0]            ramstore;
  logic [31:0]            ramload;
  logic [1:0]             ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_mem_arbiter.sv
// Serialises both cores' dcache/icache requests onto one RAM port, with snoop-wait/invalidate broadcast.
// Latency: request seen in IDLE -> grant next cycle; done on RAM ACCESS; one IDLE bubble after every release.
// Backpressure: non-granted requesters and the granted one until ACCESS see wait=1; dcache block grant held via cctrans.
// Ports: CLK, nRST (async active-low), ccif (coherence_mem_arbiter_if.slave: cache, coherence and RAM signals).
module coherence_mem_arbiter #(
  parameter int CPUS = 2  // exactly two cores; grant index is a single bit
) (
  input  logic                    CLK,
  input  logic                    nRST,
  coherence_mem_arbiter_if.slave  ccif
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GNT_D0 = 3'd1;
  localparam logic [2:0] GNT_D1 = 3'd2;
  localparam logic [2:0] GNT_I0 = 3'd3;
  localparam logic [2:0] GNT_I1 = 3'd4;

  logic [2:0]      state, state_nxt;
  logic            drr, drr_nxt;
  logic            irr, irr_nxt;
  logic            gnt_first;   // high during the first cycle of any grant
  logic [CPUS-1:0] dreq;
  logic            access;
  logic            d_gnt, i_gnt;
  logic            cur;         // core owning the current grant
  logic            oth;         // the core being snooped

  assign dreq   = ccif.dREN | ccif.dWEN;
  assign access = (ccif.ramstate == RAM_ACCESS);
  assign d_gnt  = (state == GNT_D0) || (state == GNT_D1);
  assign i_gnt  = (state == GNT_I0) || (state == GNT_I1);
  assign cur    = (state == GNT_D1) || (state == GNT_I1);
  assign oth    = ~cur;

  // Grant decision and release. A dropped request always releases; a block
  // transfer (cctrans) survives ACCESS cycles and only a plain access
  // releases on ACCESS.
  always_comb begin
    state_nxt = state;
    drr_nxt   = drr;
    irr_nxt   = irr;
    case (state)
      IDLE: begin
        if (|dreq) begin
          if (&dreq) state_nxt = drr ? GNT_D1 : GNT_D0;
          else       state_nxt = dreq[1] ? GNT_D1 : GNT_D0;
        end else if (|ccif.iREN) begin
          if (&ccif.iREN) state_nxt = irr ? GNT_I1 : GNT_I0;
          else            state_nxt = ccif.iREN[1] ? GNT_I1 : GNT_I0;
        end
      end
      GNT_D0, GNT_D1: begin
        if (!dreq[cur] || (!ccif.cctrans[cur] && access)) begin
          state_nxt = IDLE;
          drr_nxt   = oth;
        end
      end
      GNT_I0, GNT_I1: begin
        if (!ccif.iREN[cur] || access) begin
          state_nxt = IDLE;
          irr_nxt   = oth;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      drr       <= 1'b0;
      irr       <= 1'b0;
      gnt_first <= 1'b0;
    end else begin
      state     <= state_nxt;
      drr       <= drr_nxt;
      irr       <= irr_nxt;
      // every grant is entered from IDLE, so this marks its first cycle
      gnt_first <= (state == IDLE);
    end
  end

  // Load buses are shared; only the granted port's wait qualifies them.
  assign ccif.dload = {CPUS{ccif.ramload}};
  assign ccif.iload = {CPUS{ccif.ramload}};

  // RAM strobes are decoded from state so an async reset kills them at once.
  always_comb begin
    ccif.iwait       = '1;
    ccif.dwait       = '1;
    ccif.ccwait      = '0;
    ccif.ccinv       = '0;
    ccif.ccsnoopaddr = '0;
    ccif.ramREN      = 1'b0;
    ccif.ramWEN      = 1'b0;
    ccif.ramaddr     = '0;
    ccif.ramstore    = '0;
    if (d_gnt) begin
      ccif.ramaddr  = ccif.daddr[cur];
      ccif.ramstore = ccif.dstore[cur];
      // a write wins when both strobes are raised
      ccif.ramWEN   = ccif.dWEN[cur];
      ccif.ramREN   = ccif.dREN[cur] & ~ccif.dWEN[cur];
      ccif.dwait[cur]       = ~access;
      ccif.ccwait[oth]      = 1'b1;
      ccif.ccsnoopaddr[oth] = ccif.daddr[cur];
      // a read-for-ownership kills the other copy once, at grant start
      ccif.ccinv[oth] = gnt_first & ccif.dREN[cur] & ccif.ccwrite[cur];
    end else if (i_gnt) begin
      ccif.ramREN     = 1'b1;
      ccif.ramaddr    = ccif.iaddr[cur];
      ccif.iwait[cur] = ~access;
    end
  end

endmodule

// File: tb/tb_coherence_mem_arbiter.sv
// Self-checking bench for coherence_mem_arbiter: directed scenarios then randomized traffic vs a bus-ownership model.
// Latency: n/a. Backpressure: cache agents hold requests until their wait drops.
// Ports: none; drives a coherence_mem_arbiter_if instance and a behavioural RAM.
module tb_coherence_mem_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  coherence_mem_arbiter_if #(.CPUS(2)) bus();
  coherence_mem_arbiter #(.CPUS(2)) dut (.CLK(CLK), .nRST(nRST), .ccif(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram_mem [16];  // the RAM device itself (written from DUT outputs)
  logic [31:0] ref_mem [16];  // expected memory contents (written from agent intent)

  // requester index: 0 = dcache0, 1 = dcache1, 2 = icache0, 3 = icache1
  bit          act [4];
  bit          wr  [4];
  bit          rd  [4];
  bit          cw  [4];
  int          gap [4];
  logic [31:0] a   [4];
  logic [31:0] wd  [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.cctrans = '0; bus.ccwrite = '0;
    bus.ramload = '0; bus.ramstate = FREE;
  endtask

  task automatic nxt(input logic [1:0] rs, input logic [31:0] ld);
    @(posedge CLK); #1;
    bus.ramstate = rs;
    bus.ramload  = ld;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Bus-level model: one owner at a time, owner chosen when the bus is free
  // (dcache before icache, alternating between cores when both ask), grant
  // active the cycle after the choice, next choice one cycle after completion.
  task automatic run_random(input int ncyc);
    int          owner, own_start, free_cyc, w;
    bit          prr_d, prr_i, gnt, e;
    logic [1:0]  rs, dr, ir;
    owner = -1; own_start = 0; free_cyc = 0; prr_d = 1'b0; prr_i = 1'b0;
    for (int k = 0; k < 4; k++) begin act[k] = 1'b0; gap[k] = 0; end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(posedge CLK); #1;
      for (int k = 0; k < 4; k++) begin
        if (!act[k]) begin
          if (gap[k] > 0) gap[k]--;
          else if ($urandom_range(0, 2) != 0) begin
            act[k] = 1'b1;
            a[k]   = 32'($urandom_range(0, 15)) << 2;
            wd[k]  = $urandom;
            wr[k]  = (k < 2) && ($urandom_range(0, 1) == 1);
            rd[k]  = !wr[k] || ($urandom_range(0, 3) == 0);
            cw[k]  = ($urandom_range(0, 1) == 1);
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        bus.dREN[c]    = act[c] && rd[c];
        bus.dWEN[c]    = act[c] && wr[c];
        bus.daddr[c]   = a[c];
        bus.dstore[c]  = wd[c];
        bus.ccwrite[c] = cw[c];
        bus.cctrans[c] = 1'b0;
        bus.iREN[c]    = act[c+2];
        bus.iaddr[c]   = a[c+2];
      end
      #1;
      if (bus.ramREN || bus.ramWEN) begin
        w  = $urandom_range(0, 9);
        rs = (w < 5) ? BUSY : (w < 8) ? ACCESS : ERROR;
      end else begin
        rs = FREE;
      end
      bus.ramstate = rs;
      bus.ramload  = ram_mem[bus.ramaddr[5:2]];
      @(negedge CLK);

      gnt = (owner >= 0) && (cyc >= own_start);
      for (int k = 0; k < 4; k++) begin
        e = !(gnt && owner == k && rs == ACCESS);
        if (k < 2) chk("rnd_dwait", 64'(bus.dwait[k]), 64'(e));
        else       chk("rnd_iwait", 64'(bus.iwait[k-2]), 64'(e));
      end
      for (int k = 0; k < 2; k++) begin
        e = gnt && (owner == 1 - k);
        chk("rnd_ccwait", 64'(bus.ccwait[k]), 64'(e));
        if (e) chk("rnd_snoop", 64'(bus.ccsnoopaddr[k]), 64'(a[1-k]));
        chk("rnd_ccinv", 64'(bus.ccinv[k]),
            64'(e && cyc == own_start && rd[1-k] && cw[1-k]));
      end
      if (gnt) begin
        chk("rnd_ramaddr", 64'(bus.ramaddr), 64'(a[owner]));
        chk("rnd_strobe", 64'({bus.ramREN, bus.ramWEN}), wr[owner] ? 64'd1 : 64'd2);
        if (wr[owner]) chk("rnd_ramstore", 64'(bus.ramstore), 64'(wd[owner]));
      end else begin
        chk("rnd_strobe_idle", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
      end

      if (gnt && rs == ACCESS) begin
        if (!wr[owner]) begin
          if (owner < 2) chk("rnd_dload", 64'(bus.dload[owner]), 64'(ref_mem[a[owner][5:2]]));
          else           chk("rnd_iload", 64'(bus.iload[owner-2]), 64'(ref_mem[a[owner][5:2]]));
        end else begin
          ref_mem[a[owner][5:2]] = wd[owner];
        end
        act[owner] = 1'b0;
        gap[owner] = $urandom_range(0, 2);
        if (owner < 2) prr_d = (owner == 0);
        else           prr_i = (owner == 2);
        owner    = -1;
        free_cyc = cyc + 1;
      end
      if (rs == ACCESS && bus.ramWEN) ram_mem[bus.ramaddr[5:2]] = bus.ramstore;

      if (owner < 0 && cyc >= free_cyc) begin
        dr = {act[1], act[0]};
        ir = {act[3], act[2]};
        if (dr != 2'b00)      owner = (dr == 2'b11) ? int'(prr_d) : (dr[1] ? 1 : 0);
        else if (ir != 2'b00) owner = 2 + ((ir == 2'b11) ? int'(prr_i) : (ir[1] ? 1 : 0));
        own_start = cyc + 1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 32'h0100_0000 + 32'(i) * 32'h0001_0101;
      ref_mem[i] = 32'h0100_0000 + 32'(i) * 32'h0001_0101;
    end
    clr();
    nRST = 1'b0;
    #1;
    chk("rst_iwait",    64'(bus.iwait), 64'd3);
    chk("rst_dwait",    64'(bus.dwait), 64'd3);
    chk("rst_cc",       64'({bus.ccwait, bus.ccinv}), 64'd0);
    chk("rst_snoop",    64'(bus.ccsnoopaddr), 64'd0);
    chk("rst_strobe",   64'({bus.ramREN, bus.ramWEN}), 64'd0);
    chk("rst_ramaddr",  64'(bus.ramaddr), 64'd0);
    chk("rst_ramstore", 64'(bus.ramstore), 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;

    // two dcaches at once: core 0 first, one bubble, then core 1
    nxt(FREE, 0); bus.dREN = 2'b11; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h14; smp();
    chk("t2_req_wait", 64'(bus.dwait), 64'd3);
    nxt(BUSY, 0); smp();
    chk("t2_gnt0_addr", 64'(bus.ramaddr), 64'h10);
    chk("t2_gnt0_wait", 64'(bus.dwait), 64'd3);
    nxt(BUSY, 0); smp();
    nxt(ACCESS, 32'h1234); smp();
    chk("t2_d0_done", 64'(bus.dwait), 64'b10);
    chk("t2_d0_load", 64'(bus.dload[0]), 64'h1234);
    nxt(FREE, 0); bus.dREN[0] = 1'b0; smp();
    chk("t2_bubble", 64'({bus.ramREN, bus.ramWEN, bus.dwait}), 64'b0011);
    nxt(ACCESS, 32'h5678); smp();
    chk("t2_d1_addr", 64'(bus.ramaddr), 64'h14);
    chk("t2_d1_done", 64'(bus.dwait), 64'b01);
    nxt(FREE, 0); bus.dREN[1] = 1'b0; smp();

    // icache0 and dcache1 together: dcache goes first
    nxt(FREE, 0); bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h20; bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h24; smp();
    nxt(ACCESS, 32'hAAAA); smp();
    chk("t3_d_first", 64'(bus.ramaddr), 64'h24);
    chk("t3_d_done", 64'({bus.dwait, bus.iwait}), 64'b0111);
    nxt(FREE, 0); bus.dREN[1] = 1'b0; smp();
    chk("t3_i_held", 64'(bus.iwait), 64'd3);
    nxt(ACCESS, 32'hBBBB); smp();
    chk("t3_i_addr", 64'(bus.ramaddr), 64'h20);
    chk("t3_i_done", 64'({bus.iwait, bus.ramREN}), 64'b101);
    chk("t3_i_load", 64'(bus.iload[0]), 64'hBBBB);
    nxt(FREE, 0); bus.iREN[0] = 1'b0; smp();

    // read+write raised together on core 1: write wins
    nxt(FREE, 0); bus.dREN[1] = 1'b1; bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h3100; bus.dstore[1] = 32'hDEAD_BEEF; smp();
    nxt(ACCESS, 0); smp();
    chk("t6_strobe", 64'({bus.ramREN, bus.ramWEN}), 64'b01);
    chk("t6_addr", 64'(bus.ramaddr), 64'h3100);
    chk("t6_store", 64'(bus.ramstore), 64'hDEAD_BEEF);
    chk("t6_dwait", 64'(bus.dwait), 64'b01);
    nxt(FREE, 0); bus.dREN[1] = 1'b0; bus.dWEN[1] = 1'b0; smp();

    // core 0 block fill for a store: one invalidate, grant held over both words
    nxt(FREE, 0); bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1; bus.daddr[0] = 32'h100; smp();
    nxt(BUSY, 0); smp();
    chk("t4_inv_first", 64'(bus.ccinv), 64'b10);
    chk("t4_snoop", 64'(bus.ccsnoopaddr[1]), 64'h100);
    chk("t4_ccwait1", 64'(bus.ccwait), 64'b10);
    nxt(ACCESS, 32'h1111); smp();
    chk("t4_inv_once", 64'(bus.ccinv), 64'd0);
    chk("t4_w1", 64'({bus.dwait, bus.dload[0]}), {30'd0, 2'b10, 32'h1111});
    nxt(ACCESS, 32'h2222); bus.daddr[0] = 32'h104; smp();
    chk("t4_w2_addr", 64'(bus.ramaddr), 64'h104);
    chk("t4_w2", 64'({bus.dwait, bus.dload[0]}), {30'd0, 2'b10, 32'h2222});
    chk("t4_w2_cc", 64'({bus.ccwait, bus.ccinv}), 64'b1000);
    nxt(FREE, 0); bus.dREN[0] = 1'b0; bus.cctrans[0] = 1'b0; bus.ccwrite[0] = 1'b0; smp();
    nxt(FREE, 0); smp();
    chk("t4_release", 64'(bus.ccwait), 64'd0);

    // core 1 two-word writeback with ERROR cycles
    nxt(FREE, 0); bus.dWEN[1] = 1'b1; bus.cctrans[1] = 1'b1; bus.daddr[1] = 32'h200; bus.dstore[1] = 32'hA0A0_A0A0; smp();
    nxt(ERROR, 0); smp();
    chk("t5_err1", 64'({bus.ramWEN, bus.dwait, bus.ccinv}), 64'b11100);
    nxt(ACCESS, 0); smp();
    chk("t5_w1", 64'({bus.ramWEN, bus.dwait, bus.ccinv}), 64'b10100);
    chk("t5_w1_store", 64'(bus.ramstore), 64'hA0A0_A0A0);
    nxt(ERROR, 0); bus.daddr[1] = 32'h204; bus.dstore[1] = 32'hB0B0_B0B0; smp();
    chk("t5_err2", 64'({bus.ramWEN, bus.dwait, bus.ccinv}), 64'b11100);
    chk("t5_err2_addr", 64'(bus.ramaddr), 64'h204);
    nxt(ACCESS, 0); smp();
    chk("t5_w2", 64'({bus.ramWEN, bus.dwait, bus.ccinv}), 64'b10100);
    chk("t5_w2_store", 64'(bus.ramstore), 64'hB0B0_B0B0);
    nxt(FREE, 0); bus.dWEN[1] = 1'b0; bus.cctrans[1] = 1'b0; smp();
    chk("t5_drop_inv", 64'(bus.ccinv), 64'd0);
    nxt(FREE, 0); smp();

    // async reset in the middle of a write grant
    nxt(FREE, 0); bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h40; smp();
    nxt(BUSY, 0); smp();
    chk("t1_pre_wen", 64'(bus.ramWEN), 64'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t1_rst_strobe", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
    chk("t1_rst_dwait", 64'(bus.dwait), 64'd3);
    @(posedge CLK); @(negedge CLK);
    nRST = 1'b1; bus.ramstate = FREE;
    #1;
    chk("t1_idle", 64'({bus.ramWEN, bus.dwait}), 64'b011);
    bus.dWEN[0] = 1'b0;
    nxt(FREE, 0); smp();
    chk("t1_stay_idle", 64'({bus.ramREN, bus.ramWEN, bus.ccwait}), 64'd0);

    // fresh reset, then randomized traffic
    nRST = 1'b0; clr();
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    run_random(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
